// File: rtl/mem_pkg.sv
// Shared types and helpers for the CPU-side SRAM memory controller.
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_CAPT,
        WRITE,
        DONE
    } state_t;

    localparam logic [3:0] BE_ALL = 4'b1111;

    // Replace each byte lane of old_word by the matching lane of new_word where be is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_mem_ctrl.sv
// CPU load/store front end for a single-port 32-bit word SRAM with one-cycle
// read latency. Sub-word stores are done as read-modify-write.
module sram_mem_ctrl
    import mem_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ,
    output logic        READY,
    input  logic        WR,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    input  logic [3:0]  BE,
    output logic        ACK,
    output logic        ERR,
    output logic [31:0] RDATA,
    output logic [31:0] SRAM_ADDR,
    inout  wire  [31:0] SRAM_D,
    output logic        SRAM_WE,
    input  logic        SRAM_RDY
);

    state_t      state_q, state_d;
    logic [29:0] addr_q;
    logic        wr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;   // store data, becomes the merged word after a read-modify-write
    logic [31:0] rdata_q;
    logic        err_q;
    logic        we_q;      // single flop for both SRAM_WE and the bus drive enable

    logic        accept;
    logic [31:0] word_idx;
    logic        out_of_range;
    logic        unused_addr_lsbs;

    assign accept           = REQ && (state_q == IDLE);
    assign word_idx         = {2'b00, ADDR[31:2]};
    assign out_of_range     = (word_idx >= 32'(MEM_WORDS));
    assign unused_addr_lsbs = ^ADDR[1:0];

    // Next-state decode for the request sequencer.
    always_comb begin
        // NOTE: default first, so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (out_of_range)             state_d = DONE;
                    else if (WR && BE == 4'b0000) state_d = DONE;
                    else if (WR && BE == BE_ALL)  state_d = WRITE;
                    else                          state_d = RD_ADDR;
                end
            end
            RD_ADDR: if (SRAM_RDY) state_d = RD_CAPT;
            RD_CAPT: if (SRAM_RDY) state_d = wr_q ? WRITE : DONE;
            WRITE:   if (SRAM_RDY) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, request latch, read capture / merge and write-enable registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            state_q <= state_d;
            we_q    <= (state_d == WRITE);
            if (accept) begin
                addr_q  <= ADDR[31:2];
                wr_q    <= WR;
                be_q    <= BE;
                wdata_q <= WDATA;
                err_q   <= out_of_range;
                if (out_of_range) rdata_q <= '0;
            end
            if (state_q == RD_CAPT && SRAM_RDY) begin
                if (wr_q) wdata_q <= byte_merge(SRAM_D, wdata_q, be_q);
                else      rdata_q <= SRAM_D;
            end
        end
    end

    assign READY     = (state_q == IDLE);
    assign ACK       = (state_q == DONE);
    assign ERR       = ACK && err_q;
    assign RDATA     = rdata_q;
    assign SRAM_ADDR = {2'b00, addr_q};
    assign SRAM_WE   = we_q;
    assign SRAM_D    = we_q ? wdata_q : 'z;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Self-checking bench for sram_mem_ctrl: SRAM model on the shared bus plus a
// transaction-level reference of memory contents, latency and RDATA.
module tb_sram_mem_ctrl;

    localparam int MEM_WORDS = 1024;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        REQ;
    logic        READY;
    logic        WR;
    logic [31:0] ADDR;
    logic [31:0] WDATA;
    logic [3:0]  BE;
    logic        ACK;
    logic        ERR;
    logic [31:0] RDATA;
    logic [31:0] SRAM_ADDR;
    wire  [31:0] SRAM_D;
    logic        SRAM_WE;
    logic        SRAM_RDY;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    sram_mem_ctrl #(.MEM_WORDS(MEM_WORDS)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .REQ       (REQ),
        .READY     (READY),
        .WR        (WR),
        .ADDR      (ADDR),
        .WDATA     (WDATA),
        .BE        (BE),
        .ACK       (ACK),
        .ERR       (ERR),
        .RDATA     (RDATA),
        .SRAM_ADDR (SRAM_ADDR),
        .SRAM_D    (SRAM_D),
        .SRAM_WE   (SRAM_WE),
        .SRAM_RDY  (SRAM_RDY)
    );

    // SRAM model: samples address on an edge with RDY=1, drives the word the next cycle.
    logic [31:0] sram_mem [MEM_WORDS];
    logic [31:0] sram_q = '0;
    logic        sram_oe = 1'b1;

    assign SRAM_D = (sram_oe && !SRAM_WE) ? sram_q : 'z;

    always @(posedge CLK) begin
        if (SRAM_RDY && SRAM_ADDR < 32'(MEM_WORDS)) begin
            if (SRAM_WE) sram_mem[SRAM_ADDR[9:0]] <= SRAM_D;
            else         sram_q <= sram_mem[SRAM_ADDR[9:0]];
        end
    end

    // Reference state.
    logic [31:0] ref_mem [MEM_WORDS];
    logic [31:0] ref_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, optionally holding SRAM_RDY low for the first k cycles after acceptance.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int k,
                          output int lat, output logic err, output logic [31:0] rd,
                          output int we_cnt, output int rdy_hi);
        int n;
        bit got;
        @(negedge CLK);
        check("ready_before_req", {31'b0, READY}, 32'd1);
        REQ = 1'b1; WR = wr; ADDR = addr; WDATA = wdata; BE = be; SRAM_RDY = 1'b1;
        @(posedge CLK);
        n = 0; got = 0; we_cnt = 0; rdy_hi = 0; lat = -1; err = 1'b0; rd = '0;
        while (!got && n < 40) begin
            #1;
            REQ = 1'b0; WR = 1'($urandom); ADDR = $urandom; WDATA = $urandom; BE = 4'($urandom);
            SRAM_RDY = (n < k) ? 1'b0 : 1'b1;
            @(negedge CLK);
            n++;
            we_cnt += int'(SRAM_WE);
            rdy_hi += int'(READY);
            if (ACK) begin
                got = 1; lat = n; err = ERR; rd = RDATA;
            end else begin
                @(posedge CLK);
            end
        end
        @(posedge CLK);
        #1;
        SRAM_RDY = 1'b1;
    endtask

    // Run one request and compare against the reference rules.
    task automatic run_op(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int k);
        logic [29:0] word;
        bit          oor;
        int          exp_lat, exp_we, lat, we_cnt, rdy_hi;
        logic        err;
        logic [31:0] rd;
        word = addr[31:2];
        oor  = (word >= 30'(MEM_WORDS));
        exp_we = 0;
        if (oor) begin
            exp_lat = 1; ref_rdata = '0;
        end else if (!wr) begin
            exp_lat = 3; ref_rdata = ref_mem[word[9:0]];
        end else if (be == 4'b0000) begin
            exp_lat = 1;
        end else begin
            exp_lat = (be == 4'b1111) ? 2 : 4;
            exp_we  = (be == 4'b1111) ? 1 + k : 1;
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[word[9:0]][8*b +: 8] = wdata[8*b +: 8];
        end
        if (exp_lat > 1) exp_lat += k;
        do_req(wr, addr, wdata, be, k, lat, err, rd, we_cnt, rdy_hi);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_err"}, {31'b0, err}, {31'b0, oor});
        check({tag, "_rdata"}, rd, ref_rdata);
        check({tag, "_we_cycles"}, 32'(we_cnt), 32'(exp_we));
        check({tag, "_ready_low"}, 32'(rdy_hi), 32'd0);
    endtask

    initial begin
        logic        r_wr;
        logic [29:0] r_word;
        logic [31:0] r_addr;
        logic [3:0]  r_be;
        logic        bus_is_wdata;

        for (int i = 0; i < MEM_WORDS; i++) begin
            sram_mem[i] = 32'(2 * i);
            ref_mem[i]  = 32'(2 * i);
        end
        ref_rdata = '0;
        RST_N = 1'b0; REQ = 1'b0; WR = 1'b0; ADDR = '0; WDATA = '0; BE = '0; SRAM_RDY = 1'b1;

        // Reset state.
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ready", {31'b0, READY}, 32'd1);
        check("rst_ack", {31'b0, ACK}, 32'd0);
        check("rst_err", {31'b0, ERR}, 32'd0);
        check("rst_rdata", RDATA, 32'd0);
        check("rst_we", {31'b0, SRAM_WE}, 32'd0);
        check("rst_addr", SRAM_ADDR, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Basic load of word 4.
        run_op("load_w4", 1'b0, 32'h0000_0010, 32'h0, 4'h0, 0);

        // Full store to 0x40 aborted by reset in the WRITE cycle.
        @(negedge CLK);
        REQ = 1'b1; WR = 1'b1; ADDR = 32'h40; WDATA = 32'hCAFE_F00D; BE = 4'hF;
        @(posedge CLK);
        #1;
        REQ = 1'b0;
        check("abort_we_high", {31'b0, SRAM_WE}, 32'd1);
        check("abort_bus_driven", SRAM_D, 32'hCAFE_F00D);
        #2;
        RST_N = 1'b0; sram_oe = 1'b0;
        #1;
        bus_is_wdata = (SRAM_D === 32'hCAFE_F00D);
        check("abort_we_fell", {31'b0, SRAM_WE}, 32'd0);
        check("abort_bus_released", {31'b0, bus_is_wdata}, 32'd0);
        check("abort_no_ack", {31'b0, ACK}, 32'd0);
        @(posedge CLK);
        #1;
        check("abort_ready", {31'b0, READY}, 32'd1);
        check("abort_no_ack_after", {31'b0, ACK}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1; sram_oe = 1'b1; ref_rdata = '0;
        run_op("load_0x40_after_abort", 1'b0, 32'h40, 32'h0, 4'h0, 0);

        // Full store, then read back.
        run_op("store_full_0x40", 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 0);
        run_op("load_0x40", 1'b0, 32'h40, 32'h0, 4'h0, 0);

        // Partial store (read-modify-write), then read back.
        run_op("store_part_0x44", 1'b1, 32'h44, 32'h0000_AB00, 4'b0010, 0);
        run_op("load_0x44", 1'b0, 32'h44, 32'h0, 4'h0, 0);
        check("rmw_value", ref_rdata, 32'h0000_AB22);

        // Load with three stall cycles.
        run_op("load_stall_0x8", 1'b0, 32'h8, 32'h0, 4'h0, 3);

        // Out-of-range boundary: word 1024 is rejected, word 1023 is fine.
        run_op("load_oor_1024", 1'b0, 32'h0000_1000, 32'h0, 4'h0, 0);
        run_op("load_last_word", 1'b0, 32'h0000_0FFC, 32'h0, 4'h0, 0);
        run_op("store_oor", 1'b1, 32'h0000_1004, 32'h1234_5678, 4'hF, 2);
        run_op("store_be0", 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, 0);
        run_op("full_store_stall", 1'b1, 32'h0000_0024, 32'h0BAD_CAFE, 4'hF, 2);
        run_op("load_after_stall", 1'b0, 32'h0000_0024, 32'h0, 4'h0, 0);

        // Random traffic against the reference.
        for (int i = 0; i < 40; i++) begin
            r_wr   = 1'($urandom);
            r_word = ($urandom_range(0, 9) == 0) ? 30'($urandom_range(1024, 1100))
                                                 : 30'($urandom_range(0, 31));
            r_addr = {r_word, 2'($urandom)};
            case ($urandom_range(0, 3))
                0:       r_be = 4'h0;
                1:       r_be = 4'hF;
                default: r_be = 4'($urandom);
            endcase
            run_op("rand", r_wr, r_addr, $urandom, r_be, int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
